// File: rtl/dds_phase_accum.sv
// Phase accumulator for the DDS: FTW/offset staged in shadow registers, applied atomically on commit.
// phase_out trails the accumulator by one cycle; cfg_ready drops for the single cycle a commit is applied.
module dds_phase_accum #(
    parameter int ACC_W   = 24,
    parameter int PHASE_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [2:0]         cfg_addr,
    input  logic [7:0]         cfg_data,
    output logic [PHASE_W-1:0] phase_out,
    output logic               phase_valid,
    output logic               wrap
);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   ftw_shadow_q, ftw_shadow_d;
    logic [ACC_W-1:0]   ftw_active_q, ftw_active_d;
    logic [PHASE_W-1:0] off_shadow_q, off_shadow_d;
    logic [PHASE_W-1:0] off_active_q, off_active_d;
    logic [PHASE_W-1:0] phase_out_q, phase_out_d;
    logic               commit_pend_q, commit_pend_d;
    logic               clear_pend_q, clear_pend_d;
    logic               en_q, en_d;
    logic               phase_valid_q, phase_valid_d;
    logic               wrap_q, wrap_d;
    logic               cfg_fire;
    logic [ACC_W:0]     sum;

    assign cfg_ready = !commit_pend_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign sum       = {1'b0, acc_q} + {1'b0, ftw_active_q};

    always_comb begin
        ftw_shadow_d  = ftw_shadow_q;
        ftw_active_d  = ftw_active_q;
        off_shadow_d  = off_shadow_q;
        off_active_d  = off_active_q;
        acc_d         = acc_q;
        wrap_d        = 1'b0;
        phase_out_d   = phase_out_q;
        phase_valid_d = en_q;
        en_d          = en;
        commit_pend_d = cfg_fire && (cfg_addr == 3'd5) && cfg_data[0];
        clear_pend_d  = cfg_fire && (cfg_addr == 3'd5) && cfg_data[1];

        // Bytes 0..2 map to FTW bits 23:0; anything wider stays zero.
        for (int i = 0; i < ACC_W; i++) begin
            if (i < 24 && cfg_fire && cfg_addr == {1'b0, i[4:3]})
                ftw_shadow_d[i] = cfg_data[i[2:0]];
        end
        for (int i = 0; i < PHASE_W; i++) begin
            if (cfg_fire && cfg_addr == ((i < 8) ? 3'd3 : 3'd4))
                off_shadow_d[i] = cfg_data[i[2:0]];
        end

        if (commit_pend_q) begin
            ftw_active_d = ftw_shadow_q;
            off_active_d = off_shadow_q;
        end

        if (clear_pend_q) begin
            acc_d = '0;
        end else if (en) begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = sum[ACC_W];
        end

        if (en_q)
            phase_out_d = acc_q[ACC_W-1 -: PHASE_W] + off_active_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q         <= '0;
            ftw_shadow_q  <= '0;
            ftw_active_q  <= '0;
            off_shadow_q  <= '0;
            off_active_q  <= '0;
            phase_out_q   <= '0;
            commit_pend_q <= 1'b0;
            clear_pend_q  <= 1'b0;
            en_q          <= 1'b0;
            phase_valid_q <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            ftw_shadow_q  <= ftw_shadow_d;
            ftw_active_q  <= ftw_active_d;
            off_shadow_q  <= off_shadow_d;
            off_active_q  <= off_active_d;
            phase_out_q   <= phase_out_d;
            commit_pend_q <= commit_pend_d;
            clear_pend_q  <= clear_pend_d;
            en_q          <= en_d;
            phase_valid_q <= phase_valid_d;
            wrap_q        <= wrap_d;
        end
    end

    assign phase_out   = phase_out_q;
    assign phase_valid = phase_valid_q;
    assign wrap        = wrap_q;

endmodule

// File: tb/tb_dds_phase_accum.sv
// Directed bench for dds_phase_accum: stimulus pushes expected (phase, wrap) pairs,
// a forked monitor pops one entry per cycle in which phase_valid is high.
module tb_dds_phase_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_data;
    logic [13:0] phase_out;
    logic        phase_valid;
    logic        wrap;

    typedef struct {
        logic [13:0] ph;
        logic        wr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dds_phase_accum #(.ACC_W(24), .PHASE_W(14)) dut (
        .clk(clk), .rst(rst), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .phase_out(phase_out), .phase_valid(phase_valid), .wrap(wrap)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [7:0] d);
        int guard = 0;
        while (!cfg_ready && guard < 10) begin
            tick(1);
            guard++;
        end
        if (!cfg_ready) check("cfg_ready_timeout", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic push(input logic [13:0] ph, input logic wr);
        exp_t e;
        e.ph = ph;
        e.wr = wr;
        exp_q.push_back(e);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (!rst && phase_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_phase_valid", 32'(phase_out), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("phase_out", 32'(phase_out), 32'(e.ph));
                        check("wrap", 32'(wrap), 32'(e.wr));
                    end
                end
            end
        join_none

        // Reset with a pending write and en high: nothing must stick.
        rst = 1'b1; en = 1'b1; cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_data = 8'hFF;
        tick(2);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        rst = 1'b0; en = 1'b0; cfg_valid = 1'b0;
        tick(1);
        check("rst_phase_out", 32'(phase_out), 32'd0);
        check("rst_phase_valid", 32'(phase_valid), 32'd0);
        check("rst_wrap", 32'(wrap), 32'd0);
        check("rst_cfg_ready_after", 32'(cfg_ready), 32'd1);

        // Commit the untouched shadows: FTW must still be 0.
        cfg_wr(3'd5, 8'h01);
        tick(2);
        for (int k = 0; k < 3; k++) push(14'd0, 1'b0);
        en = 1'b1; tick(3); en = 0; tick(2);

        // Basic tone: FTW 0x040000, clear+commit, 70 steps.
        cfg_wr(3'd0, 8'h00);
        cfg_wr(3'd1, 8'h00);
        cfg_wr(3'd2, 8'h04);
        cfg_wr(3'd5, 8'h03);
        check("commit_ready_low", 32'(cfg_ready), 32'd0);
        tick(1);
        check("commit_ready_back", 32'(cfg_ready), 32'd1);
        for (int k = 1; k <= 70; k++)
            push(14'((k * 256) % 16384), (k == 63));
        en = 1'b1; tick(70); en = 1'b0; tick(3);

        // Shadow isolation: acc starts at 0x180000, FTW 0x040000 then 0x080000.
        begin
            logic [13:0] tbl [10];
            tbl = '{14'd1792, 14'd2048, 14'd2304, 14'd2560, 14'd2816,
                    14'd3072, 14'd3584, 14'd4096, 14'd4608, 14'd5120};
            for (int k = 0; k < 10; k++) push(tbl[k], 1'b0);
        end
        en = 1'b1;
        tick(3);
        cfg_wr(3'd2, 8'h08);
        cfg_wr(3'd5, 8'h01);
        check("commit2_ready_low", 32'(cfg_ready), 32'd0);
        tick(5);
        en = 1'b0;
        tick(3);

        // Offset 0x3FFF with FTW 0 (addr 4 excess bits ignored).
        cfg_wr(3'd2, 8'h00);
        cfg_wr(3'd3, 8'hFF);
        cfg_wr(3'd4, 8'hFF);
        cfg_wr(3'd5, 8'h03);
        tick(2);
        for (int k = 0; k < 3; k++) push(14'h3FFF, 1'b0);
        en = 1'b1; tick(3); en = 1'b0; tick(2);
        cfg_wr(3'd1, 8'h04);
        cfg_wr(3'd5, 8'h01);
        tick(2);
        push(14'h0000, 1'b0); push(14'h0001, 1'b0); push(14'h0002, 1'b0);
        en = 1'b1; tick(3); en = 1'b0; tick(2);

        // Clear+commit mid-sweep: FTW 0x100000, offset 0x0010.
        push(14'h0003, 1'b0); push(14'h0004, 1'b0); push(14'h0005, 1'b0);
        push(14'h0006, 1'b0); push(14'h0007, 1'b0); push(14'h0010, 1'b0);
        push(14'h0410, 1'b0); push(14'h0810, 1'b0); push(14'h0C10, 1'b0);
        en = 1'b1;
        cfg_wr(3'd1, 8'h00);
        cfg_wr(3'd2, 8'h10);
        cfg_wr(3'd3, 8'h10);
        cfg_wr(3'd4, 8'h00);
        cfg_wr(3'd5, 8'h03);
        tick(4);
        en = 1'b0;
        tick(3);

        // en gating at acc = 0x100000.
        cfg_wr(3'd5, 8'h02);
        check("clear_only_ready", 32'(cfg_ready), 32'd1);
        tick(2);
        push(14'h0410, 1'b0);
        en = 1'b1; tick(1); en = 1'b0;
        tick(1);
        for (int k = 0; k < 4; k++) begin
            tick(1);
            check("gate_phase_valid", 32'(phase_valid), 32'd0);
            check("gate_wrap", 32'(wrap), 32'd0);
            check("gate_phase_hold", 32'(phase_out), 32'h0410);
        end
        push(14'h0810, 1'b0); push(14'h0C10, 1'b0); push(14'h1010, 1'b0);
        en = 1'b1; tick(3); en = 1'b0; tick(3);

        // FTW = 2^23: wrap every second step.
        cfg_wr(3'd2, 8'h80);
        cfg_wr(3'd3, 8'h00);
        cfg_wr(3'd5, 8'h03);
        tick(2);
        push(14'h2000, 1'b1); push(14'h0000, 1'b0);
        push(14'h2000, 1'b1); push(14'h0000, 1'b0);
        en = 1'b1; tick(4); en = 1'b0; tick(4);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dds_phase_accum.md
Name: dds_phase_accum

Overview:
- Numerically controlled phase generator that sits directly upstream of the sine lookup stage in the tiny DDS top level.
- Holds an ACC_W-bit phase accumulator stepped by a frequency tuning word (FTW) every enabled cycle.
- Emits a PHASE_W-bit truncated, offset-adjusted phase word each cycle.
- FTW and phase offset are loaded byte-wise over a valid/ready config port into shadow registers, then applied atomically by a commit write.

Parameters:
ACC_W, 24, accumulator and FTW width in bits (16..32)
PHASE_W, 14, output phase width; must be <= ACC_W and <= 16

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
en  input  1  accumulate enable
cfg_valid  input  1  config write request
cfg_ready  output  1  config port can accept a write
cfg_addr  input  3  config register address
cfg_data  input  8  config write data
phase_out  output  PHASE_W  registered phase word to the sine stage
phase_valid  output  1  phase_out updated this cycle
wrap  output  1  one-cycle pulse: accumulator overflowed past 2^ACC_W

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high. While rst is high at a rising edge, all state clears:
  - acc, ftw_shadow, ftw_active, off_shadow, off_active = 0
  - phase_out = 0, phase_valid = 0, wrap = 0, cfg_ready = 1
  - A pending commit is discarded.
- Config write is accepted on an edge where cfg_valid && cfg_ready.
- Address map:
  - 0/1/2: ftw_shadow bits [7:0]/[15:8]/[23:16]. Bits at or above ACC_W are ignored; for ACC_W > 24, addr 2 also feeds bits above 23 through bit ACC_W-1 is not possible, so ACC_W > 24 upper bits stay 0.
  - 3: off_shadow[7:0]
  - 4: off_shadow[PHASE_W-1:8]; excess data bits are ignored.
  - 5: control. bit0 = commit, bit1 = clear accumulator. Other bits are ignored.
  - 6, 7: accepted and ignored.
- Commit:
  - An accepted addr-5 write with bit0 set raises commit_pend.
  - On the next edge, ftw_active <= ftw_shadow and off_active <= off_shadow.
  - cfg_ready is low for exactly that one cycle, then returns to 1.
  - Shadow writes never affect output until committed.
- Clear:
  - An accepted addr-5 write with bit1 set forces acc <= 0 on the following edge. This overrides the increment and ignores en.
  - Commit and clear together: both happen on the same edge. The first increment after that uses the new ftw_active.
- Accumulator (each edge, not clearing):
  - If en: {carry, acc} <= acc + ftw_active, with the ACC_W-bit modulo wrap; wrap <= carry.
  - Else: acc holds and wrap <= 0.
- Output stage, registered one cycle behind acc:
  - If en was high on the previous edge: phase_out <= (acc[ACC_W-1 -: PHASE_W] + off_active) mod 2^PHASE_W and phase_valid <= 1.
  - Else: phase_out holds and phase_valid <= 0.
  - Latency: an FTW committed at edge N first changes acc at edge N+1 and phase_out at edge N+2.
- en low mid-stream: acc freezes. Re-asserting en resumes from the frozen value with no lost or duplicated steps.
- rst mid-commit, or with cfg_valid high: reset wins and the write is not accepted.
- FTW = 0 with en = 1: acc constant, phase_valid = 1, wrap never pulses.
- FTW = 2^(ACC_W-1): acc alternates 0 / 2^(ACC_W-1), and wrap pulses every second step.

Test Plan:
- Reset: assert rst for 2 cycles with cfg_valid = 1 and en = 1 -> all outputs 0, cfg_ready = 1, no register changed after release.
- Basic tone (defaults): write 0x00/0x00/0x04 to addr 0/1/2, commit, en = 1 -> phase_out steps by 256 per cycle (0, 256, 512, …, 16128, 0). wrap pulses every 64 cycles, exactly on the acc 0xFC0000 -> 0x000000 step. phase_valid is 1 continuously.
- Shadow isolation and latency: while running FTW 0x040000, write FTW 0x080000 without commit -> step stays 256. Write commit -> cfg_ready low one cycle, step becomes 512 at the second edge after commit acceptance.
- Offset: commit off = 0x3FFF (addr 3 = 0xFF, addr 4 = 0x3F) with FTW 0 after clear -> phase_out = 0x3FFF constant. Change FTW to 0x000400 -> phase_out sequence 0x3FFF, 0x0000, 0x0001 (mod wrap).
- Clear + commit simultaneous: write addr 5 = 0x03 mid-sweep -> acc = 0 on the next edge, the next increment uses the new FTW, and phase_out shows off_active then off_active + step.
- en gating: drop en for 5 cycles at acc = 0x100000 -> phase_valid = 0, phase_out and acc frozen, wrap = 0. On re-enable, the sequence continues from 0x100000 + FTW.
